// File: rtl/sram_pkg.sv
// Shared types and sizing helpers for the single-port masked SRAM model.
package sram_pkg;

    typedef enum logic {
        READ  = 1'b0,
        WRITE = 1'b1
    } req_kind_e;

    typedef enum logic {
        INIT  = 1'b0,
        READY = 1'b1
    } arr_state_e;

    // Index / sweep counter width; a DEPTH of 2 still needs one bit.
    function automatic int sweep_cnt_width(input int depth);
        return (depth <= 2) ? 1 : $clog2(depth);
    endfunction

endpackage

// File: rtl/sram_1p_core.sv
// Pure storage: masked write port, registered read address, combinational read-out.
// Deliberately reset-free so a foundry macro can be dropped in its place.
module sram_1p_core #(
    parameter int DEPTH    = 2048,
    parameter int WIDTH    = 16,
    parameter int MASK_SEG = 1,
    parameter int AW       = 11
) (
    input  logic                clock,
    input  logic                we,
    input  logic                re,
    input  logic [AW-1:0]       addr,
    input  logic [WIDTH-1:0]    wdata,
    input  logic [MASK_SEG-1:0] wmask,
    output logic [WIDTH-1:0]    rdata
);

    localparam int SW = WIDTH / MASK_SEG;

    logic [WIDTH-1:0] mem_q [DEPTH];
    logic [AW-1:0]    raddr_q;

    // Segment-masked write and read-address capture
    always_ff @(posedge clock) begin
        if (we) begin
            for (int i = 0; i < MASK_SEG; i++) begin
                if (wmask[i]) begin
                    mem_q[addr][i*SW +: SW] <= wdata[i*SW +: SW];
                end
            end
        end
        if (re) begin
            raddr_q <= addr;
        end
    end

    assign rdata = mem_q[raddr_q];

endmodule

// File: rtl/sram_1p_masked_array.sv
// Parametrised single-port array: valid/ready requests, post-reset zero sweep,
// read response with optional output stage and a hold register.
module sram_1p_masked_array
    import sram_pkg::*;
#(
    parameter int DEPTH     = 2048,
    parameter int WIDTH     = 16,
    parameter int MASK_SEG  = 1,
    parameter int INIT_ZERO = 1,
    parameter int OUT_REG   = 0,
    localparam int AW       = sweep_cnt_width(DEPTH)
) (
    input  logic                clock,
    input  logic                reset,
    input  logic                req_valid,
    output logic                req_ready,
    input  logic [AW-1:0]       req_addr,
    input  logic                req_wmode,
    input  logic [WIDTH-1:0]    req_wdata,
    input  logic [MASK_SEG-1:0] req_wmask,
    output logic                resp_valid,
    output logic [WIDTH-1:0]    resp_rdata,
    output logic                init_done
);

    localparam arr_state_e    RST_STATE = (INIT_ZERO != 0) ? INIT : READY;
    localparam logic [AW:0]   DEPTH_W   = (AW+1)'(DEPTH);
    localparam logic [AW-1:0] LAST_IDX  = AW'(DEPTH - 1);

    arr_state_e          state_q, state_d;
    logic [AW-1:0]       sweep_q, sweep_d;
    logic                ready_q, ready_d;
    logic                rd_v1_q, oor1_q;

    logic                accept_s, in_range_s;
    req_kind_e           kind_s;
    logic                core_we_s, core_re_s;
    logic [AW-1:0]       core_addr_s;
    logic [WIDTH-1:0]    core_wdata_s, core_rdata_s, rdata1_s;
    logic [MASK_SEG-1:0] core_wmask_s;

    assign accept_s   = req_valid && ready_q;
    assign in_range_s = ({1'b0, req_addr} < DEPTH_W);
    assign kind_s     = req_kind_e'(req_wmode);

    // Sweep FSM next state; ready is registered so it rises with the state change
    always_comb begin
        state_d = state_q;
        sweep_d = sweep_q;
        case (state_q)
            INIT: begin
                if (sweep_q == LAST_IDX) begin
                    state_d = READY;
                    sweep_d = '0;
                end else begin
                    sweep_d = sweep_q + AW'(1);
                end
            end
            READY: begin
                state_d = READY;
            end
            default: begin
                state_d = RST_STATE;
                sweep_d = '0;
            end
        endcase
        ready_d = (state_d == READY);
    end

    // State, sweep counter and handshake registers
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state_q <= RST_STATE;
            sweep_q <= '0;
            ready_q <= 1'b0;
        end else begin
            state_q <= state_d;
            sweep_q <= sweep_d;
            ready_q <= ready_d;
        end
    end

    // Core port mux: sweep owns the port during INIT; out-of-range writes are dropped
    always_comb begin
        if (state_q == INIT) begin
            core_we_s    = 1'b1;
            core_re_s    = 1'b0;
            core_addr_s  = sweep_q;
            core_wdata_s = '0;
            core_wmask_s = '1;
        end else begin
            core_we_s    = accept_s && (kind_s == WRITE) && in_range_s;
            core_re_s    = accept_s && (kind_s == READ);
            core_addr_s  = req_addr;
            core_wdata_s = req_wdata;
            core_wmask_s = req_wmask;
        end
    end

    sram_1p_core #(
        .DEPTH    (DEPTH),
        .WIDTH    (WIDTH),
        .MASK_SEG (MASK_SEG),
        .AW       (AW)
    ) u_core (
        .clock (clock),
        .we    (core_we_s),
        .re    (core_re_s),
        .addr  (core_addr_s),
        .wdata (core_wdata_s),
        .wmask (core_wmask_s),
        .rdata (core_rdata_s)
    );

    // First read stage: valid plus out-of-range flag travel alongside the core's address
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            rd_v1_q <= 1'b0;
            oor1_q  <= 1'b0;
        end else begin
            rd_v1_q <= core_re_s;
            oor1_q  <= core_re_s && !in_range_s;
        end
    end

    assign rdata1_s = oor1_q ? '0 : core_rdata_s;

    generate
        if (OUT_REG != 0) begin : g_out_reg
            logic             rd_v2_q;
            logic [WIDTH-1:0] data2_q;

            // Output stage doubles as the hold register
            always_ff @(posedge clock or posedge reset) begin
                if (reset) begin
                    rd_v2_q <= 1'b0;
                    data2_q <= '0;
                end else begin
                    rd_v2_q <= rd_v1_q;
                    if (rd_v1_q) begin
                        data2_q <= rdata1_s;
                    end
                end
            end

            assign resp_valid = rd_v2_q;
            assign resp_rdata = data2_q;
        end else begin : g_out_comb
            logic [WIDTH-1:0] hold_q;

            // Remember the last response so idle cycles never expose raw array output
            always_ff @(posedge clock or posedge reset) begin
                if (reset) begin
                    hold_q <= '0;
                end else if (rd_v1_q) begin
                    hold_q <= rdata1_s;
                end
            end

            assign resp_valid = rd_v1_q;
            assign resp_rdata = rd_v1_q ? rdata1_s : hold_q;
        end
    endgenerate

    assign req_ready = ready_q;
    assign init_done = ready_q;

endmodule

// File: tb/tb_sram_1p_masked_array.sv
// Directed bench: five array instances covering sweep, masking, output stage,
// out-of-range handling and mid-operation reset.
module tb_sram_1p_masked_array;

    logic        clock;
    logic        reset;
    logic        v    [5];
    logic        we   [5];
    logic [10:0] addr [5];
    logic [15:0] wd   [5];
    logic [1:0]  mk   [5];
    logic        rdy  [5];
    logic        rv   [5];
    logic [15:0] rd   [5];
    logic        done [5];

    int n_tests = 0;
    int n_fail  = 0;
    int n;

    always #5 clock = ~clock;

    // 0: DEPTH 16 with sweep
    sram_1p_masked_array #(.DEPTH(16), .WIDTH(16), .MASK_SEG(1), .INIT_ZERO(1), .OUT_REG(0)) u_a (
        .clock(clock), .reset(reset), .req_valid(v[0]), .req_ready(rdy[0]),
        .req_addr(addr[0][3:0]), .req_wmode(we[0]), .req_wdata(wd[0]), .req_wmask(mk[0][0:0]),
        .resp_valid(rv[0]), .resp_rdata(rd[0]), .init_done(done[0]));

    // 1: default parameters
    sram_1p_masked_array u_b (
        .clock(clock), .reset(reset), .req_valid(v[1]), .req_ready(rdy[1]),
        .req_addr(addr[1][10:0]), .req_wmode(we[1]), .req_wdata(wd[1]), .req_wmask(mk[1][0:0]),
        .resp_valid(rv[1]), .resp_rdata(rd[1]), .init_done(done[1]));

    // 2: two mask segments, no sweep
    sram_1p_masked_array #(.DEPTH(16), .WIDTH(16), .MASK_SEG(2), .INIT_ZERO(0), .OUT_REG(0)) u_c (
        .clock(clock), .reset(reset), .req_valid(v[2]), .req_ready(rdy[2]),
        .req_addr(addr[2][3:0]), .req_wmode(we[2]), .req_wdata(wd[2]), .req_wmask(mk[2][1:0]),
        .resp_valid(rv[2]), .resp_rdata(rd[2]), .init_done(done[2]));

    // 3: output register stage
    sram_1p_masked_array #(.DEPTH(16), .WIDTH(16), .MASK_SEG(1), .INIT_ZERO(0), .OUT_REG(1)) u_d (
        .clock(clock), .reset(reset), .req_valid(v[3]), .req_ready(rdy[3]),
        .req_addr(addr[3][3:0]), .req_wmode(we[3]), .req_wdata(wd[3]), .req_wmask(mk[3][0:0]),
        .resp_valid(rv[3]), .resp_rdata(rd[3]), .init_done(done[3]));

    // 4: non-power-of-two depth
    sram_1p_masked_array #(.DEPTH(12), .WIDTH(16), .MASK_SEG(1), .INIT_ZERO(1), .OUT_REG(0)) u_e (
        .clock(clock), .reset(reset), .req_valid(v[4]), .req_ready(rdy[4]),
        .req_addr(addr[4][3:0]), .req_wmode(we[4]), .req_wdata(wd[4]), .req_wmask(mk[4][0:0]),
        .resp_valid(rv[4]), .resp_rdata(rd[4]), .init_done(done[4]));

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    // Called just after a falling edge; presents one request for exactly one rising edge
    task automatic req(input int k, input logic wm, input logic [10:0] a,
                       input logic [15:0] d, input logic [1:0] m);
        v[k]    = 1'b1;
        we[k]   = wm;
        addr[k] = a;
        wd[k]   = d;
        mk[k]   = m;
        @(negedge clock);
        v[k]    = 1'b0;
    endtask

    initial begin
        clock = 1'b0;
        reset = 1'b1;
        for (int k = 0; k < 5; k++) begin
            v[k] = 1'b0; we[k] = 1'b0; addr[k] = 11'd0; wd[k] = 16'd0; mk[k] = 2'd0;
        end
        repeat (3) @(negedge clock);

        check_eq("rst_ready",       32'(rdy[0]),  32'd0);
        check_eq("rst_resp_valid",  32'(rv[0]),   32'd0);
        check_eq("rst_rdata",       32'(rd[0]),   32'd0);
        check_eq("rst_init_done",   32'(done[0]), 32'd0);
        check_eq("rst_done_noinit", 32'(done[2]), 32'd0);

        reset = 1'b0;
        n = 0;
        while (!rdy[0] && n < 100) begin
            @(negedge clock);
            n++;
        end
        check_eq("init_cycles", 32'(n),       32'd16);
        check_eq("init_done",   32'(done[0]), 32'd1);
        check_eq("noinit_ready", 32'(rdy[2]), 32'd1);

        req(0, 1'b0, 11'd5, 16'd0, 2'd0);
        check_eq("swept_rv",    32'(rv[0]), 32'd1);
        check_eq("swept_rdata", 32'(rd[0]), 32'h0000);
        @(negedge clock);
        check_eq("swept_rv_pulse", 32'(rv[0]), 32'd0);

        req(2, 1'b1, 11'd3, 16'hFFFF, 2'b11);
        req(2, 1'b1, 11'd3, 16'h1234, 2'b01);
        req(2, 1'b0, 11'd3, 16'd0, 2'd0);
        check_eq("mask_rv",    32'(rv[2]), 32'd1);
        check_eq("mask_lo",    32'(rd[2]), 32'hFF34);
        req(2, 1'b1, 11'd3, 16'h5678, 2'b00);
        req(2, 1'b0, 11'd3, 16'd0, 2'd0);
        check_eq("mask_none",  32'(rd[2]), 32'hFF34);
        req(2, 1'b1, 11'd3, 16'hABCD, 2'b10);
        req(2, 1'b0, 11'd3, 16'd0, 2'd0);
        check_eq("mask_hi",    32'(rd[2]), 32'hAB34);

        req(3, 1'b1, 11'd1, 16'h0011, 2'b01);
        req(3, 1'b1, 11'd2, 16'h0022, 2'b01);
        req(3, 1'b1, 11'd3, 16'h0033, 2'b01);
        v[3] = 1'b1; we[3] = 1'b0; addr[3] = 11'd1;
        @(negedge clock);
        check_eq("oreg_lat_rv", 32'(rv[3]), 32'd0);
        addr[3] = 11'd2;
        @(negedge clock);
        check_eq("oreg_r1_rv", 32'(rv[3]), 32'd1);
        check_eq("oreg_r1",    32'(rd[3]), 32'h0011);
        addr[3] = 11'd3;
        @(negedge clock);
        check_eq("oreg_r2_rv", 32'(rv[3]), 32'd1);
        check_eq("oreg_r2",    32'(rd[3]), 32'h0022);
        v[3] = 1'b0;
        @(negedge clock);
        check_eq("oreg_r3_rv", 32'(rv[3]), 32'd1);
        check_eq("oreg_r3",    32'(rd[3]), 32'h0033);
        @(negedge clock);
        check_eq("oreg_idle_rv", 32'(rv[3]), 32'd0);
        check_eq("oreg_hold",    32'(rd[3]), 32'h0033);

        check_eq("d12_ready", 32'(rdy[4]), 32'd1);
        req(4, 1'b1, 11'd1,  16'h0101, 2'b01);
        req(4, 1'b1, 11'd13, 16'hBEEF, 2'b01);
        req(4, 1'b0, 11'd13, 16'd0, 2'd0);
        check_eq("oor_rv",    32'(rv[4]), 32'd1);
        check_eq("oor_rdata", 32'(rd[4]), 32'h0000);
        req(4, 1'b0, 11'd1, 16'd0, 2'd0);
        check_eq("oor_addr1", 32'(rd[4]), 32'h0101);

        n = 0;
        while (!rdy[1] && n < 3000) begin
            @(negedge clock);
            n++;
        end
        check_eq("dflt_ready", 32'(rdy[1]), 32'd1);
        req(1, 1'b1, 11'h3FF, 16'hA5C3, 2'b01);
        req(1, 1'b0, 11'h3FF, 16'd0, 2'd0);
        check_eq("dflt_rv",    32'(rv[1]), 32'd1);
        check_eq("dflt_rdata", 32'(rd[1]), 32'hA5C3);
        @(negedge clock);
        check_eq("dflt_idle_rv", 32'(rv[1]), 32'd0);
        check_eq("dflt_hold",    32'(rd[1]), 32'hA5C3);

        req(0, 1'b0, 11'd7, 16'd0, 2'd0);
        check_eq("inflight_rv", 32'(rv[0]), 32'd1);
        reset = 1'b1;
        #1;
        check_eq("reset_drop_rv",    32'(rv[0]), 32'd0);
        check_eq("reset_clear_data", 32'(rd[0]), 32'd0);
        @(negedge clock);
        reset = 1'b0;
        repeat (7) @(negedge clock);
        check_eq("sweep7_ready", 32'(rdy[0]), 32'd0);
        reset = 1'b1;
        @(negedge clock);
        reset = 1'b0;
        n = 0;
        while (!rdy[0] && n < 100) begin
            @(negedge clock);
            n++;
        end
        check_eq("resweep_cycles", 32'(n), 32'd16);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
